fc_layer_sequencer: RTL and testbench
=====================================

// Module: fc_layer_sequencer
// PURPOSE
//  Sequences one fully-connected int8 layer on the 4-lane MAC datapath: issues input/weight/bias
//  memory reads, drives the datapath's en/valid/flush/bias_add/ReLU controls, waits on its done,
//  and writes one packed 4x int8 result word per 4 output neurons. Sits between the layer-level
//  control CPU/FSM and the MAC datapath.
// PARAMETERS
//  ADDR_W     12    width of every memory address port
//  LEN_W      12    width of cfg_in_len / cfg_out_groups
//  TIMEOUT    255   mac_done wait limit in cycles (used only with FC_SEQ_TIMEOUT_EN)
// PORTS
//  clk             in   1       clock
//  rstn            in   1       asynchronous active-low reset
//  start           in   1       1-cycle pulse; sampled only in IDLE
//  cfg_in_len      in   LEN_W   input length in int8 elements (1..2^LEN_W-1)
//  cfg_out_groups  in   LEN_W   number of 4-neuron output groups (>=1)
//  cfg_relu        in   1       apply ReLU clamp to the layer outputs
//  busy            out  1       high from the cycle after an accepted start until DONE
//  done            out  1       1-cycle pulse when the last result word is written
//  err             out  1       sticky mac_done timeout flag; cleared by start
//  mem_rd_en       out  1       read strobe; data reaches the datapath the next cycle
//  in_addr         out  ADDR_W  input-feature word address
//  w_addr          out  ADDR_W  weight word address
//  b_addr          out  ADDR_W  bias word address (= group index)
//  mac_en          out  1       datapath enable
//  mac_valid       out  4       per-lane valid mask
//  mac_flush       out  1       clear datapath accumulator
//  mac_bias_add    out  1       apply the bias word, pack and saturate the group
//  mac_relu        out  1       = cfg_relu latched at start
//  mac_done        in   1       datapath completion for the last issued operation
//  out_we          out  1       result write strobe (the datapath's packed out_data is the write data)
//  out_addr        out  ADDR_W  result word address (= group index)
// BEHAVIOUR
//  - Reset: every output 0, FSM in IDLE, all counters 0.
//  - start in IDLE latches cfg_*; in_words = ceil(cfg_in_len/4); clears err. start while busy: ignored.
//  - States: IDLE -> FLUSH -> WFL -> FETCH -> MAC -> WMAC -> (FETCH | FLUSH | BFETCH) ;
//            BFETCH -> BIAS -> WBIAS -> WRITE -> (FLUSH | DONE) ; DONE -> IDLE.
//  - FLUSH: mac_en=1, mac_flush=1 for 1 cycle. WFL: hold until mac_done.
//  - FETCH: mem_rd_en=1, in_addr=k, w_addr=wptr. MAC (next cycle): mac_en=1 for 1 cycle,
//    mac_valid=4'hF, or on the last word (k==in_words-1) the low (cfg_in_len mod 4) bits set
//    (4'hF if mod==0). WMAC: hold until mac_done, then k++ and wptr++.
//  - Exactly one of mac_flush, mac_bias_add or a plain MAC issue is active per mac_en cycle.
//  - After the last word: k=0. If lane<3: lane++ and go to FLUSH. Else go to BFETCH.
//  - wptr runs continuously, so weights are neuron-major and contiguous: neuron n, word k
//    -> n*in_words + k. It is never reset between neurons.
//  - BFETCH: mem_rd_en=1, b_addr=grp. BIAS: mac_en=1, mac_bias_add=1 for 1 cycle. WBIAS: wait mac_done.
//  - WRITE: out_we=1 for exactly 1 cycle, out_addr=grp. Then lane=0 and grp++.
//    If grp was cfg_out_groups-1: go to DONE, else go to FLUSH.
//  - DONE: done=1 for 1 cycle; busy drops in the same cycle; return to IDLE.
//  - mac_done outside a W* state is ignored. Reset mid-layer aborts immediately
//    (no partial write completes).
//  - Counters are modulo 2^ADDR_W. Address wrap is the caller's responsibility (not checked).
// CONFIGURATION
//  FC_SEQ_TIMEOUT_EN defined: a wait counter runs in WFL/WMAC/WBIAS. When it reaches TIMEOUT
//    with no mac_done: set err, pulse done, go to IDLE.
//  Undefined: W* states wait forever; err is tied 0.
// STRUCTURE
//  fc_seq_pkg: state encoding localparams, lane-count constant (4), valid-mask lookup function.
//  Sub-module fc_seq_addr_gen: the k/wptr/lane/grp counters and the address outputs.
//  The FSM stays in the top level.
// TESTING
//  1. len=8, groups=1, done 1 cycle after each en -> w_addr 0..7, in_addr 0,1 per neuron;
//     4 flushes; 1 bias_add; out_we at addr 0; done pulse.
//  2. len=6 -> last MAC of each neuron has mac_valid=4'b0011; len=4 -> always 4'hF.
//  3. groups=2, len=4 -> b_addr/out_addr 0 then 1; w_addr 0..7; done exactly once.
//  4. start pulsed during busy and mac_done pulsed in FETCH -> no effect on the sequence.
//  5. rstn low during WMAC of neuron 2 -> all outputs 0 next edge; a new start runs cleanly from w_addr 0.
//  6. FC_SEQ_TIMEOUT_EN, TIMEOUT=10, mac_done withheld -> err=1 and done after 10 cycles; next start clears err.

Source files
------------

// File: rtl/fc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fc_seq_pkg
// Brief    : Shared constants, state encoding and lane valid-mask helper for
//            the fully-connected layer sequencer.
// Revision : 1.0  initial release
// ============================================================================
package fc_seq_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = $clog2(LANES);

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_FLUSH  = 4'd1;
  localparam logic [3:0] ST_WFL    = 4'd2;
  localparam logic [3:0] ST_FETCH  = 4'd3;
  localparam logic [3:0] ST_MAC    = 4'd4;
  localparam logic [3:0] ST_WMAC   = 4'd5;
  localparam logic [3:0] ST_BFETCH = 4'd6;
  localparam logic [3:0] ST_BIAS   = 4'd7;
  localparam logic [3:0] ST_WBIAS  = 4'd8;
  localparam logic [3:0] ST_WRITE  = 4'd9;
  localparam logic [3:0] ST_DONE   = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE   = ST_IDLE,
    S_FLUSH  = ST_FLUSH,
    S_WFL    = ST_WFL,
    S_FETCH  = ST_FETCH,
    S_MAC    = ST_MAC,
    S_WMAC   = ST_WMAC,
    S_BFETCH = ST_BFETCH,
    S_BIAS   = ST_BIAS,
    S_WBIAS  = ST_WBIAS,
    S_WRITE  = ST_WRITE,
    S_DONE   = ST_DONE
  } state_t;

  // Only the final input word of a neuron can be partial; a zero remainder means a full word.
  function automatic logic [LANES-1:0] valid_mask(input logic last, input logic [1:0] len_mod);
    if (!last || (len_mod == 2'd0))
      return '1;
    else
      return (4'd1 << len_mod) - 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fc_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fc_seq_if
// Brief    : Memory-read, MAC-control and result-write bus between the
//            sequencer (master) and the MAC datapath (slave).
// Revision : 1.0  initial release
// ============================================================================
interface fc_seq_if
  import fc_seq_pkg::*;
#(
  parameter int ADDR_W = 12
) ();

  logic              mem_rd_en;
  logic [ADDR_W-1:0] in_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] b_addr;
  logic              mac_en;
  logic [LANES-1:0]  mac_valid;
  logic              mac_flush;
  logic              mac_bias_add;
  logic              mac_relu;
  logic              mac_done;
  logic              out_we;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output mem_rd_en, in_addr, w_addr, b_addr,
    output mac_en, mac_valid, mac_flush, mac_bias_add, mac_relu,
    input  mac_done,
    output out_we, out_addr
  );

  modport slave (
    input  mem_rd_en, in_addr, w_addr, b_addr,
    input  mac_en, mac_valid, mac_flush, mac_bias_add, mac_relu,
    output mac_done,
    input  out_we, out_addr
  );

endinterface
`default_nettype wire

// File: rtl/fc_seq_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : fc_seq_addr_gen
// Brief    : Word / weight-pointer / lane / group counters that generate every
//            memory address of the layer sequence.
// Revision : 1.0  initial release
// ============================================================================
module fc_seq_addr_gen
  import fc_seq_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 12
) (
  input  wire logic              clk,
  input  wire logic              rstn,
  input  wire logic              init,
  input  wire logic              adv_word,
  input  wire logic              adv_grp,
  input  wire logic [LEN_W-1:0]  in_words,
  input  wire logic [LEN_W-1:0]  out_groups,
  output logic      [ADDR_W-1:0] k,
  output logic      [ADDR_W-1:0] wptr,
  output logic      [LANE_W-1:0] lane,
  output logic      [ADDR_W-1:0] grp,
  output logic                   last_word,
  output logic                   last_lane,
  output logic                   last_grp
);

  assign last_word = (k == ADDR_W'(in_words - 1'b1));
  assign last_lane = (lane == LANE_W'(LANES - 1));
  assign last_grp  = (grp == ADDR_W'(out_groups - 1'b1));

  // wptr is never rewound between neurons: weights are laid out neuron-major and contiguous.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k    <= '0;
      wptr <= '0;
      lane <= '0;
      grp  <= '0;
    end else if (init) begin
      k    <= '0;
      wptr <= '0;
      lane <= '0;
      grp  <= '0;
    end else begin
      if (adv_word) begin
        wptr <= wptr + 1'b1;
        if (last_word) begin
          k <= '0;
          if (!last_lane)
            lane <= lane + 1'b1;
        end else begin
          k <= k + 1'b1;
        end
      end
      if (adv_grp) begin
        lane <= '0;
        grp  <= grp + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fc_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fc_layer_sequencer
// Brief    : Sequences one int8 fully-connected layer on the 4-lane MAC
//            datapath. Optional mac_done watchdog: FC_SEQ_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module fc_layer_sequencer
  import fc_seq_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LEN_W   = 12,
  parameter int TIMEOUT = 255
) (
  input  wire logic             clk,
  input  wire logic             rstn,
  input  wire logic             start,
  input  wire logic [LEN_W-1:0] cfg_in_len,
  input  wire logic [LEN_W-1:0] cfg_out_groups,
  input  wire logic             cfg_relu,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  fc_seq_if.master              dp
);

  state_t            state, state_nxt;
  logic              accept;
  logic [LEN_W-1:0]  in_words_r;
  logic [LEN_W-1:0]  out_groups_r;
  logic [1:0]        len_mod_r;
  logic              relu_r;
  logic              timed_out;

  logic              rd_en, mac_en, flush, bias_add, we, adv_word, adv_grp;
  logic [LANES-1:0]  valid;

  logic [ADDR_W-1:0] k, wptr, grp;
  logic [LANE_W-1:0] lane;
  logic              last_word, last_lane, last_grp;

  assign accept = (state == S_IDLE) && start;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_words_r   <= '0;
      out_groups_r <= '0;
      len_mod_r    <= '0;
      relu_r       <= 1'b0;
    end else if (accept) begin
      in_words_r   <= LEN_W'(({1'b0, cfg_in_len} + (LEN_W+1)'(3)) >> 2);
      out_groups_r <= cfg_out_groups;
      len_mod_r    <= cfg_in_len[1:0];
      relu_r       <= cfg_relu;
    end
  end

`ifdef FC_SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              err_r;

  assign waiting   = (state == S_WFL) || (state == S_WMAC) || (state == S_WBIAS);
  assign timed_out = waiting && !dp.mac_done && (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign err       = err_r;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= '0;
      err_r    <= 1'b0;
    end else begin
      wait_cnt <= (waiting && !dp.mac_done) ? wait_cnt + 1'b1 : '0;
      if (accept)
        err_r <= 1'b0;
      else if (timed_out)
        err_r <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    mac_en    = 1'b0;
    valid     = '0;
    flush     = 1'b0;
    bias_add  = 1'b0;
    we        = 1'b0;
    adv_word  = 1'b0;
    adv_grp   = 1'b0;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_FLUSH;
      S_FLUSH: begin
        mac_en    = 1'b1;
        flush     = 1'b1;
        state_nxt = S_WFL;
      end
      S_WFL: begin
        if (dp.mac_done)    state_nxt = S_FETCH;
        else if (timed_out) state_nxt = S_DONE;
      end
      S_FETCH: begin
        rd_en     = 1'b1;
        state_nxt = S_MAC;
      end
      S_MAC: begin
        mac_en    = 1'b1;
        valid     = valid_mask(last_word, len_mod_r);
        state_nxt = S_WMAC;
      end
      S_WMAC: begin
        if (dp.mac_done) begin
          adv_word = 1'b1;
          if (!last_word)      state_nxt = S_FETCH;
          else if (!last_lane) state_nxt = S_FLUSH;
          else                 state_nxt = S_BFETCH;
        end else if (timed_out) begin
          state_nxt = S_DONE;
        end
      end
      S_BFETCH: begin
        rd_en     = 1'b1;
        state_nxt = S_BIAS;
      end
      S_BIAS: begin
        mac_en    = 1'b1;
        bias_add  = 1'b1;
        state_nxt = S_WBIAS;
      end
      S_WBIAS: begin
        if (dp.mac_done)    state_nxt = S_WRITE;
        else if (timed_out) state_nxt = S_DONE;
      end
      S_WRITE: begin
        we        = 1'b1;
        adv_grp   = 1'b1;
        state_nxt = last_grp ? S_DONE : S_FLUSH;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  fc_seq_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk        (clk),
    .rstn       (rstn),
    .init       (accept),
    .adv_word   (adv_word),
    .adv_grp    (adv_grp),
    .in_words   (in_words_r),
    .out_groups (out_groups_r),
    .k          (k),
    .wptr       (wptr),
    .lane       (lane),
    .grp        (grp),
    .last_word  (last_word),
    .last_lane  (last_lane),
    .last_grp   (last_grp)
  );

  assign busy            = (state != S_IDLE) && (state != S_DONE);
  assign done            = (state == S_DONE);

  assign dp.mem_rd_en    = rd_en;
  assign dp.in_addr      = k;
  assign dp.w_addr       = wptr;
  assign dp.b_addr       = grp;
  assign dp.mac_en       = mac_en;
  assign dp.mac_valid    = valid;
  assign dp.mac_flush    = flush;
  assign dp.mac_bias_add = bias_add;
  assign dp.mac_relu     = relu_r;
  assign dp.out_we       = we;
  assign dp.out_addr     = grp;

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_layer_sequencer
// Brief    : Directed self-checking bench for fc_layer_sequencer with a
//            one-cycle-latency datapath responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_fc_layer_sequencer;
  import fc_seq_pkg::*;

  localparam int ADDR_W  = 12;
  localparam int LEN_W   = 12;
  localparam int TIMEOUT = 10;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] cfg_in_len = '0;
  logic [LEN_W-1:0] cfg_out_groups = '0;
  logic             cfg_relu = 1'b0;
  logic             busy, done, err;

  fc_seq_if #(.ADDR_W(ADDR_W)) bus ();

  fc_layer_sequencer #(
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .cfg_in_len     (cfg_in_len),
    .cfg_out_groups (cfg_out_groups),
    .cfg_relu       (cfg_relu),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .dp             (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Event log captured on the falling edge
  logic [ADDR_W-1:0] f_in, f_w, f_b;
  int mac_in_q[$], mac_w_q[$], mac_v_q[$], bias_q[$], out_q[$];
  int flush_cnt = 0, done_cnt = 0, relu_seen = 0, overlap = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.mac_en && bus.mac_flush && bus.mac_bias_add) overlap++;
      if (bus.mac_en && bus.mac_flush)
        flush_cnt++;
      else if (bus.mac_en && bus.mac_bias_add)
        bias_q.push_back(int'(f_b));
      else if (bus.mac_en) begin
        mac_in_q.push_back(int'(f_in));
        mac_w_q.push_back(int'(f_w));
        mac_v_q.push_back(int'(bus.mac_valid));
        relu_seen = int'(bus.mac_relu);
      end
      if (bus.out_we) out_q.push_back(int'(bus.out_addr));
      if (done) done_cnt++;
      if (bus.mem_rd_en) begin
        f_in = bus.in_addr;
        f_w  = bus.w_addr;
        f_b  = bus.b_addr;
      end
    end
  end

  // Datapath model: mac_done one cycle after each mac_en; optional stray pulses during reads
  logic respond = 1'b1;
  logic inject  = 1'b0;
  logic en_seen = 1'b0;

  always begin
    @(negedge clk);
    en_seen = bus.mac_en;
    if (inject && bus.mem_rd_en) bus.mac_done = 1'b1;
    @(posedge clk);
    #1;
    bus.mac_done = en_seen && respond;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic clear_log();
    mac_in_q.delete(); mac_w_q.delete(); mac_v_q.delete();
    bias_q.delete(); out_q.delete();
    flush_cnt = 0; done_cnt = 0; relu_seen = 0; overlap = 0;
  endtask

  task automatic run_layer(input int len, input int groups, input int relu, input string nm);
    int iw, cyc, idx, exp_v;
    clear_log();
    cfg_in_len     = LEN_W'(len);
    cfg_out_groups = LEN_W'(groups);
    cfg_relu       = relu[0];
    pulse_start();
    check_eq({nm, "_busy_after_start"}, busy, 1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 5000) begin
      tick(1);
      cyc++;
    end
    check_eq({nm, "_done_seen"}, (done_cnt != 0), 1);
    tick(3);
    check_eq({nm, "_busy_after_done"}, busy, 0);
    check_eq({nm, "_done_count"}, done_cnt, 1);
    check_eq({nm, "_err"}, err, 0);
    check_eq({nm, "_strobe_overlap"}, overlap, 0);
    iw = (len + 3) / 4;
    check_eq({nm, "_mac_count"}, mac_w_q.size(), 4 * groups * iw);
    check_eq({nm, "_flush_count"}, flush_cnt, 4 * groups);
    check_eq({nm, "_relu"}, relu_seen, relu);
    for (int n = 0; n < 4 * groups; n++) begin
      for (int kk = 0; kk < iw; kk++) begin
        idx = n * iw + kk;
        exp_v = ((kk == iw - 1) && (len % 4 != 0)) ? ((1 << (len % 4)) - 1) : 15;
        if (idx < mac_w_q.size()) begin
          check_eq($sformatf("%s_w_addr[%0d]", nm, idx), mac_w_q[idx], idx);
          check_eq($sformatf("%s_in_addr[%0d]", nm, idx), mac_in_q[idx], kk);
          check_eq($sformatf("%s_valid[%0d]", nm, idx), mac_v_q[idx], exp_v);
        end
      end
    end
    check_eq({nm, "_bias_count"}, bias_q.size(), groups);
    check_eq({nm, "_write_count"}, out_q.size(), groups);
    for (int g = 0; g < groups; g++) begin
      if (g < bias_q.size()) check_eq($sformatf("%s_b_addr[%0d]", nm, g), bias_q[g], g);
      if (g < out_q.size())  check_eq($sformatf("%s_out_addr[%0d]", nm, g), out_q[g], g);
    end
  endtask

  initial begin
    int cyc;
    bus.mac_done = 1'b0;
    rstn = 1'b0;
    tick(3);
    check_eq("rst_busy_done_err", {busy, done, err}, 0);
    check_eq("rst_mac_ctrl", {bus.mac_en, bus.mac_valid, bus.mac_flush, bus.mac_bias_add, bus.mac_relu}, 0);
    check_eq("rst_rd_we", {bus.mem_rd_en, bus.out_we}, 0);
    check_eq("rst_in_w_addr", {bus.in_addr, bus.w_addr}, 0);
    check_eq("rst_b_out_addr", {bus.b_addr, bus.out_addr}, 0);
    rstn = 1'b1;
    tick(2);

    run_layer(8, 1, 0, "t1");

    run_layer(6, 1, 1, "t2");
    if (mac_v_q.size() > 1) check_eq("t2_len6_last_valid", mac_v_q[1], 4'b0011);
    if (mac_v_q.size() > 0) check_eq("t2_len6_first_valid", mac_v_q[0], 4'hF);
    run_layer(4, 1, 0, "t2b");

    run_layer(4, 2, 0, "t3");

    // Stray start (with different cfg) mid-layer and mac_done during reads must be ignored
    inject = 1'b1;
    fork
      run_layer(8, 1, 0, "t4");
      begin
        tick(20);
        cfg_in_len = 12'd12;
        start = 1'b1;
        tick(1);
        start = 1'b0;
      end
    join
    inject = 1'b0;

    // Asynchronous reset while waiting on the first MAC of neuron 2
    clear_log();
    cfg_in_len = 12'd8; cfg_out_groups = 12'd1; cfg_relu = 1'b1;
    pulse_start();
    cyc = 0;
    while (mac_w_q.size() < 5 && cyc < 200) begin
      tick(1);
      cyc++;
    end
    check_eq("t5_reached_neuron2", (mac_w_q.size() >= 5), 1);
    rstn = 1'b0;
    #1;
    check_eq("t5_ctrl_zero", {busy, done, err, bus.mem_rd_en, bus.mac_en, bus.mac_valid,
                              bus.mac_flush, bus.mac_bias_add, bus.mac_relu, bus.out_we}, 0);
    check_eq("t5_addr_zero", {bus.in_addr, bus.w_addr}, 0);
    check_eq("t5_baddr_zero", {bus.b_addr, bus.out_addr}, 0);
    tick(2);
    check_eq("t5_no_write", out_q.size(), 0);
    check_eq("t5_no_done", done_cnt, 0);
    rstn = 1'b1;
    tick(2);
    run_layer(8, 1, 1, "t5");

`ifdef FC_SEQ_TIMEOUT_EN
    respond = 1'b0;
    clear_log();
    cfg_in_len = 12'd4; cfg_out_groups = 12'd1; cfg_relu = 1'b0;
    pulse_start();
    cyc = 0;
    while (done_cnt == 0 && cyc < 200) begin
      tick(1);
      cyc++;
    end
    check_eq("t6_timeout_done", done_cnt, 1);
    check_eq("t6_timeout_cycles", cyc, 12);
    check_eq("t6_err_set", err, 1);
    tick(2);
    check_eq("t6_idle_busy", busy, 0);
    respond = 1'b1;
    run_layer(4, 1, 0, "t6_recover");
`else
    respond = 1'b0;
    clear_log();
    cfg_in_len = 12'd4; cfg_out_groups = 12'd1; cfg_relu = 1'b0;
    pulse_start();
    tick(40);
    check_eq("t6_wait_forever_busy", busy, 1);
    check_eq("t6_no_err", err, 0);
    check_eq("t6_no_done", done_cnt, 0);
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    respond = 1'b1;
    tick(2);
    run_layer(4, 1, 0, "t6_recover");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
